// File: rtl/tone_mixer.sv
// tone_mixer
//   Multi-channel square-wave tone generator with per-channel millisecond
//   duration timers and a first-order sigma-delta mixer that drives the
//   differential speaker pins. Software programs raw half-period divisors.
//
// Ports
//   raw_clk       clock
//   reset         synchronous, active-high
//   enable        block selected for read
//   address[5:0]  register address
//   data_in[7:0]  write data
//   write_enable  write strobe, one cycle per byte
//   data_out[7:0] registered read data
//   channel_out   raw per-channel square waves
//   busy          OR of all channel active bits
//   speaker_p     mixed PDM output
//   speaker_m     complement of speaker_p while sounding
//
// Register map
//   4c+0 div[7:0]   4c+1 div[DIV_WIDTH-1:8]
//   4c+2 dur[7:0]   4c+3 dur[DUR_WIDTH-1:8]   (reads return remaining)
//   0x20 W start mask, 0x21 W stop mask, 0x22 R active mask,
//   0x23 RW bit0 master_en
//
// Bus handshake: a write is taken on any raw_clk edge with write_enable=1
// and its effect is visible the following cycle. A read is taken on an edge
// with enable=1 and write_enable=0; data_out carries the result from that
// edge on and holds its value until the next read.
module tone_mixer #(
    parameter int CHANNELS  = 4,
    parameter int DIV_WIDTH = 16,
    parameter int DUR_WIDTH = 16,
    parameter int TICK_DIV  = 12000
) (
    input  logic                raw_clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [5:0]          address,
    input  logic [7:0]          data_in,
    input  logic                write_enable,
    output logic [7:0]          data_out,
    output logic [CHANNELS-1:0] channel_out,
    output logic                busy,
    output logic                speaker_p,
    output logic                speaker_m
);

    localparam int TW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    // acc + sum never exceeds 2*CHANNELS-1 = 15 for CHANNELS <= 8
    localparam int ACC_W = 5;
    localparam logic [ACC_W-1:0] CH_ACC   = ACC_W'(CHANNELS);
    localparam logic [TW-1:0]    TICK_TOP = TW'(TICK_DIV - 1);

    logic [DIV_WIDTH-1:0] div_q     [CHANNELS];
    logic [DUR_WIDTH-1:0] dur_q     [CHANNELS];
    logic [DUR_WIDTH-1:0] remaining [CHANNELS];
    logic [DIV_WIDTH-1:0] phase     [CHANNELS];
    logic [CHANNELS-1:0]  active;
    logic                 master_en;

    logic [TW-1:0]        tick_cnt;
    logic                 tick;

    logic [ACC_W-1:0]     acc;
    logic [ACC_W-1:0]     acc_n;
    logic [ACC_W-1:0]     sum;
    logic                 pdm;

    logic                 ch_wr;
    logic                 start_wr;
    logic                 stop_wr;
    logic                 ctrl_wr;
    logic [7:0]           rd_data;
    logic [15:0]          div_ext;
    logic [15:0]          rem_ext;

    assign ch_wr    = write_enable && !address[5];
    assign start_wr = write_enable && (address == 6'h20);
    assign stop_wr  = write_enable && (address == 6'h21);
    assign ctrl_wr  = write_enable && (address == 6'h23);

    assign busy = |active;

    // ---------------------------------------------------------------
    // Free-running duration tick
    // ---------------------------------------------------------------
    assign tick = (tick_cnt == TICK_TOP);

    always_ff @(posedge raw_clk) begin
        if (reset) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // ---------------------------------------------------------------
    // Control register
    // ---------------------------------------------------------------
    always_ff @(posedge raw_clk) begin
        if (reset) begin
            master_en <= 1'b0;
        end else if (ctrl_wr) begin
            master_en <= data_in[0];
        end
    end

    // ---------------------------------------------------------------
    // Channel registers, phase counters and duration timers
    // ---------------------------------------------------------------
    always_ff @(posedge raw_clk) begin
        if (reset) begin
            for (int c = 0; c < CHANNELS; c++) begin
                div_q[c]       <= '0;
                dur_q[c]       <= '0;
                remaining[c]   <= '0;
                phase[c]       <= '0;
                active[c]      <= 1'b0;
                channel_out[c] <= 1'b0;
            end
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (ch_wr && (address[4:2] == 3'(c))) begin
                    case (address[1:0])
                        2'd0: div_q[c][7:0]           <= data_in;
                        2'd1: div_q[c][DIV_WIDTH-1:8] <= data_in[DIV_WIDTH-9:0];
                        2'd2: dur_q[c][7:0]           <= data_in;
                        default: dur_q[c][DUR_WIDTH-1:8] <= data_in[DUR_WIDTH-9:0];
                    endcase
                end

                // Start has priority over stop and over an expiry in the
                // same cycle.
                if (start_wr && data_in[c]) begin
                    active[c]      <= 1'b1;
                    phase[c]       <= '0;
                    channel_out[c] <= 1'b0;
                    remaining[c]   <= dur_q[c];
                end else if (stop_wr && data_in[c]) begin
                    active[c]      <= 1'b0;
                    phase[c]       <= '0;
                    channel_out[c] <= 1'b0;
                end else if (active[c]) begin
                    if (tick && (remaining[c] == DUR_WIDTH'(1))) begin
                        // Last tick of the note: behaves exactly like stop.
                        active[c]      <= 1'b0;
                        phase[c]       <= '0;
                        channel_out[c] <= 1'b0;
                        remaining[c]   <= '0;
                    end else begin
                        // remaining == 0 means "play until stopped".
                        if (tick && (remaining[c] != '0)) begin
                            remaining[c] <= remaining[c] - 1'b1;
                        end
                        // >= rather than == so a divisor lowered below the
                        // current count wraps immediately.
                        if (phase[c] >= div_q[c]) begin
                            phase[c]       <= '0;
                            channel_out[c] <= ~channel_out[c];
                        end else begin
                            phase[c] <= phase[c] + 1'b1;
                        end
                    end
                end
            end
        end
    end

    // ---------------------------------------------------------------
    // First-order sigma-delta mixer
    // ---------------------------------------------------------------
    always_comb begin
        sum = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            sum = sum + ACC_W'(channel_out[c]);
        end
        acc_n = acc + sum;
        pdm   = (acc_n >= CH_ACC);
    end

    always_ff @(posedge raw_clk) begin
        if (reset) begin
            acc       <= '0;
            speaker_p <= 1'b0;
            speaker_m <= 1'b0;
        end else if (master_en && busy) begin
            speaker_p <= pdm;
            speaker_m <= ~pdm;
            acc       <= pdm ? (acc_n - CH_ACC) : acc_n;
        end else begin
            acc       <= '0;
            speaker_p <= 1'b0;
            speaker_m <= 1'b0;
        end
    end

    // ---------------------------------------------------------------
    // Read mux and registered read data
    // ---------------------------------------------------------------
    always_comb begin
        rd_data = '0;
        div_ext = '0;
        rem_ext = '0;
        if (!address[5]) begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (address[4:2] == 3'(c)) begin
                    div_ext[DIV_WIDTH-1:0] = div_q[c];
                    rem_ext[DUR_WIDTH-1:0] = remaining[c];
                end
            end
            case (address[1:0])
                2'd0:    rd_data = div_ext[7:0];
                2'd1:    rd_data = div_ext[15:8];
                2'd2:    rd_data = rem_ext[7:0];
                default: rd_data = rem_ext[15:8];
            endcase
        end else if (address == 6'h22) begin
            rd_data[CHANNELS-1:0] = active;
        end else if (address == 6'h23) begin
            rd_data[0] = master_en;
        end
    end

    always_ff @(posedge raw_clk) begin
        if (reset) begin
            data_out <= '0;
        end else if (enable && !write_enable) begin
            data_out <= rd_data;
        end
    end

endmodule

// File: tb/tb_tone_mixer.sv
// tb_tone_mixer
//   Directed bench for tone_mixer (CHANNELS=4, TICK_DIV=10). Register reads
//   push their expected byte into exp_q; a monitor pops and compares when
//   the read result appears on data_out. Pin-level observations (tone
//   periods, mixer duty, reset behaviour) are compared directly.
module tb_tone_mixer;

    localparam int CH = 4;

    logic          raw_clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic [5:0]    address = '0;
    logic [7:0]    data_in = '0;
    logic          write_enable = 1'b0;
    logic [7:0]    data_out;
    logic [CH-1:0] channel_out;
    logic          busy;
    logic          speaker_p;
    logic          speaker_m;

    tone_mixer #(
        .CHANNELS (CH),
        .DIV_WIDTH(16),
        .DUR_WIDTH(16),
        .TICK_DIV (10)
    ) dut (
        .raw_clk     (raw_clk),
        .reset       (reset),
        .enable      (enable),
        .address     (address),
        .data_in     (data_in),
        .write_enable(write_enable),
        .data_out    (data_out),
        .channel_out (channel_out),
        .busy        (busy),
        .speaker_p   (speaker_p),
        .speaker_m   (speaker_m)
    );

    // ---------------- clock ----------------
    always #5 raw_clk = ~raw_clk;

    // ---------------- scoreboard ----------------
    int         pass_cnt = 0;
    int         total_cnt = 0;
    logic [7:0] exp_q[$];
    string      name_q[$];
    logic       rd_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // data_out is valid after every edge that took a read
    always @(posedge raw_clk) rd_valid <= enable && !write_enable && !reset;

    always @(negedge raw_clk) begin
        if (rd_valid) begin
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL rd_unexpected: got 0x%0h with no expected entry", data_out);
            end else begin
                check(name_q.pop_front(), 32'(data_out), 32'(exp_q.pop_front()));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge raw_clk);
        #1;
    endtask

    task automatic wr(input logic [5:0] a, input logic [7:0] d);
        address      = a;
        data_in      = d;
        write_enable = 1'b1;
        step();
        write_enable = 1'b0;
    endtask

    task automatic rd(input logic [5:0] a, input logic [7:0] exp, input string name);
        exp_q.push_back(exp);
        name_q.push_back(name);
        address = a;
        enable  = 1'b1;
        step();
        enable  = 1'b0;
    endtask

    // cycles until channel_out[idx] changes, bounded
    task automatic wait_change(input int idx, output int n);
        logic v;
        v = channel_out[idx];
        n = 0;
        do begin
            step();
            n++;
        end while (channel_out[idx] == v && n < 200);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int cnt_p;
        int cnt_m;
        int tog;
        int hi2;
        int w;
        logic prev;

        repeat (3) step();
        reset = 1'b0;

        // Reset state
        check("rst_speaker_p", 32'(speaker_p), 0);
        check("rst_speaker_m", 32'(speaker_m), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_channel_out", 32'(channel_out), 0);
        check("rst_data_out", 32'(data_out), 0);
        for (int a = 0; a <= 'h23; a++) begin
            rd(6'(a), 8'h00, $sformatf("rst_rd_%02h", a));
        end

        // Register readback, out-of-range channel, unmapped address
        wr(6'h01, 8'h12);
        rd(6'h01, 8'h12, "div0_hi_readback");
        wr(6'h10, 8'hAA);
        rd(6'h10, 8'h00, "ch4_ignored");
        rd(6'h30, 8'h00, "unmapped_rd");

        // Ch0 div=9, dur=0, master on
        wr(6'h00, 8'h09);
        wr(6'h01, 8'h00);
        wr(6'h02, 8'h00);
        wr(6'h03, 8'h00);
        wr(6'h23, 8'h01);
        rd(6'h23, 8'h01, "master_en_rd");
        wr(6'h20, 8'h01);
        check("ch0_busy", 32'(busy), 1);
        check("ch0_start_low", 32'(channel_out[0]), 0);
        wait_change(0, n);
        check("ch0_first_half", 32'(n), 10);
        // high phase: acc 0->1->2->3->0(pdm)->... gives 2 pulses in 10
        cnt_p = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            cnt_p += 32'(speaker_p);
        end
        check("ch0_duty_high", 32'(cnt_p), 2);
        check("ch0_fall_at_10", 32'(channel_out[0]), 0);
        cnt_p = 0;
        cnt_m = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            cnt_p += 32'(speaker_p);
            cnt_m += 32'(speaker_m);
        end
        check("ch0_duty_low_p", 32'(cnt_p), 0);
        check("ch0_duty_low_m", 32'(cnt_m), 10);
        check("ch0_rise_at_20", 32'(channel_out[0]), 1);
        wr(6'h21, 8'h01);
        check("ch0_stop_out", 32'(channel_out), 0);
        check("ch0_stop_busy", 32'(busy), 0);
        step();
        check("idle_speaker_p", 32'(speaker_p), 0);
        check("idle_speaker_m", 32'(speaker_m), 0);

        // Ch1 div=2, dur=3 ticks of 10 cycles
        wr(6'h04, 8'h02);
        wr(6'h05, 8'h00);
        wr(6'h06, 8'h03);
        wr(6'h07, 8'h00);
        wr(6'h20, 8'h02);
        n = 1;
        rd(6'h22, 8'h02, "ch1_active_mask");
        n++;
        while (busy && n < 100) begin
            step();
            n++;
        end
        check("ch1_dur_in_range", 32'(n >= 21 && n <= 30), 1);
        rd(6'h22, 8'h00, "ch1_active_drop");
        rd(6'h06, 8'h00, "ch1_remaining_lo");
        rd(6'h07, 8'h00, "ch1_remaining_hi");
        check("ch1_out_after_expiry", 32'(channel_out[1]), 0);

        // Ch2 div=100, lowered to 20 with the counter at 59
        wr(6'h08, 8'd100);
        wr(6'h09, 8'h00);
        wr(6'h0A, 8'h00);
        wr(6'h0B, 8'h00);
        wr(6'h20, 8'h04);
        repeat (59) step();
        check("ch2_before_change", 32'(channel_out[2]), 0);
        wr(6'h08, 8'd20);
        step();
        check("ch2_div_lower_wrap", 32'(channel_out[2]), 1);
        wait_change(2, n);
        check("ch2_half_period_a", 32'(n), 21);
        wait_change(2, n);
        check("ch2_half_period_b", 32'(n), 21);

        // Ch1 (div=2, endless) and ch2 both active, then stop ch2
        wr(6'h06, 8'h00);
        wr(6'h20, 8'h02);
        wr(6'h21, 8'h04);
        check("stop_ch2_out", 32'(channel_out[2]), 0);
        check("stop_ch2_busy", 32'(busy), 1);
        tog = 0;
        hi2 = 0;
        prev = channel_out[1];
        for (int i = 0; i < 12; i++) begin
            step();
            if (channel_out[1] != prev) tog++;
            prev = channel_out[1];
            hi2 += 32'(channel_out[2]);
        end
        check("ch1_keeps_toggling", 32'(tog), 4);
        check("ch2_stays_low", 32'(hi2), 0);
        check("sounding_complement", 32'(speaker_p ^ speaker_m), 1);
        wr(6'h23, 8'h00);
        step();
        check("mute_speaker_p", 32'(speaker_p), 0);
        check("mute_speaker_m", 32'(speaker_m), 0);
        rd(6'h23, 8'h00, "master_en_off_rd");

        // Reset mid-note with ch3 running
        wr(6'h0C, 8'h05);
        wr(6'h23, 8'h01);
        wr(6'h20, 8'h08);
        repeat (8) step();
        rd(6'h0C, 8'h05, "ch3_div_rd");
        reset = 1'b1;
        step();
        check("midrst_channel_out", 32'(channel_out), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_speaker_p", 32'(speaker_p), 0);
        check("midrst_speaker_m", 32'(speaker_m), 0);
        check("midrst_data_out", 32'(data_out), 0);
        reset = 1'b0;
        wr(6'h20, 8'h08);
        check("ch3_restart_low", 32'(channel_out[3]), 0);
        check("ch3_restart_busy", 32'(busy), 1);
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("ch3_div0_cycle%0d", i), 32'(channel_out[3]), 32'((i + 1) % 2));
        end
        rd(6'h0C, 8'h00, "ch3_div_cleared");
        rd(6'h23, 8'h00, "master_en_cleared");

        // drain scoreboard
        w = 0;
        while (exp_q.size() != 0 && w < 20) begin
            step();
            w++;
        end
        if (exp_q.size() != 0) begin
            total_cnt++;
            $display("FAIL rd_drain: %0d reads never returned, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
